link_test_sequencer: RTL

- Controller that sequences the word-aligner/PRBS7-checker datapath through bring-up and a bit-error measurement.
- Pulses the aligner's active-low reset, waits for lock with a timeout, lets the link settle, then accumulates per-word PRBS errors over a fixed window.
- Retries on timeout or lock loss, up to a limit, and reports pass/fail, lock address and error total to the test/slow-control layer.

---
 rtl/link_test_sequencer_pkg.sv | 29 ++
 rtl/link_test_sequencer_if.sv | 24 ++
 rtl/link_test_sequencer_sat_accum.sv | 41 ++++
 rtl/link_test_sequencer.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/link_test_sequencer_pkg.sv
// State encodings, fixed timing constants and small helpers shared by the link test sequencer.
package link_test_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_RESET_DP  = 3'd1;
  localparam state_t ST_WAIT_LOCK = 3'd2;
  localparam state_t ST_SETTLE    = 3'd3;
  localparam state_t ST_MEASURE   = 3'd4;
  localparam state_t ST_DONE      = 3'd5;

  localparam int RESET_DP_CYCLES = 4;
  localparam int ERR_W_DEF       = 32;
  localparam int ECNT_W          = 6;
  localparam int ADDR_W          = 5;
  localparam int RETRY_W         = 4;

  // One spare bit over the log2 so a terminal count never wraps.
  function automatic int cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction

  function automatic logic is_busy(input state_t s);
    return (s == ST_RESET_DP) || (s == ST_WAIT_LOCK) ||
           (s == ST_SETTLE)   || (s == ST_MEASURE);
  endfunction

endpackage

// File: rtl/link_test_sequencer_if.sv
// Sequencer <-> aligner/PRBS checker datapath connection.
interface link_test_sequencer_if;
  import link_test_pkg::*;

  logic              aligned_i;
  logic [ECNT_W-1:0] error_count_i;
  logic [ADDR_W-1:0] align_addr_i;
  logic              extract_rst_n_o;

  modport master (
    input  aligned_i,
    input  error_count_i,
    input  align_addr_i,
    output extract_rst_n_o
  );

  modport slave (
    output aligned_i,
    output error_count_i,
    output align_addr_i,
    input  extract_rst_n_o
  );

endinterface

// File: rtl/link_test_sequencer_sat_accum.sv
// Saturating error accumulator; clear beats enable and the sum sticks at all-ones.
// nxt_o is the value an enabled cycle would store, so callers can judge the final total early.
module sat_accum
  import link_test_pkg::*;
#(
  parameter int W = ERR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [ECNT_W-1:0] add_i,
  output logic [W-1:0]      acc_o,
  output logic [W-1:0]      nxt_o
);

  logic [W-1:0] acc_q, acc_d;
  logic [W:0]   sum;

  always_comb begin
    sum   = {1'b0, acc_q} + (W+1)'(add_i);
    nxt_o = sum[W] ? '1 : sum[W-1:0];
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = nxt_o;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/link_test_sequencer.sv
// Brings the aligner out of reset, waits for lock, settles, then counts PRBS errors over a window,
// retrying failed attempts; all status outputs are registered.
module link_test_sequencer
  import link_test_pkg::*;
#(
  parameter int LOCK_TIMEOUT  = 8192,
  parameter int SETTLE_CYCLES = 16,
  parameter int MEAS_CYCLES   = 65536,
  parameter int MAX_RETRY     = 3,
  parameter int ERR_THRESH    = 0,
  parameter int ERR_W         = ERR_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  link_test_sequencer_if.master dp,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 lock_lost,
  output logic [RETRY_W-1:0]   retry_count,
  output logic [ADDR_W-1:0]    lock_addr,
  output logic [ERR_W-1:0]     err_total,
  output logic [2:0]           state_o
);

  localparam int CW_A  = (cnt_w(LOCK_TIMEOUT) > cnt_w(SETTLE_CYCLES)) ?
                         cnt_w(LOCK_TIMEOUT) : cnt_w(SETTLE_CYCLES);
  localparam int CW_B  = (cnt_w(MEAS_CYCLES) > cnt_w(RESET_DP_CYCLES)) ?
                         cnt_w(MEAS_CYCLES) : cnt_w(RESET_DP_CYCLES);
  localparam int CNT_W = (CW_A > CW_B) ? CW_A : CW_B;

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RESET_DP_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] MEAS_LAST   = CNT_W'(MEAS_CYCLES - 1);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [RETRY_W-1:0]   retry_q, retry_d;
  logic                 lost_q, lost_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic                 pass_q, pass_d;
  logic                 busy_q, done_q, ext_q;
  logic                 fail_attempt;
  logic                 acc_clr, acc_en;
  logic [ERR_W-1:0]     acc_nxt;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    retry_d      = retry_q;
    lost_d       = lost_q;
    addr_d       = addr_q;
    pass_d       = pass_q;
    acc_clr      = 1'b0;
    acc_en       = 1'b0;
    fail_attempt = 1'b0;

    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_d = ST_RESET_DP;
            cnt_d   = '0;
            retry_d = '0;
            lost_d  = 1'b0;
            addr_d  = '0;
            pass_d  = 1'b0;
            acc_clr = 1'b1;
          end
        end
        ST_RESET_DP: begin
          if (cnt_q == RST_LAST) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_WAIT_LOCK: begin
          // Lock on the timeout cycle still counts as a lock.
          if (dp.aligned_i) begin
            addr_d  = dp.align_addr_i;
            state_d = ST_SETTLE;
            cnt_d   = '0;
          end else if (cnt_q == LOCK_LAST) begin
            fail_attempt = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_SETTLE: begin
          if (!dp.aligned_i) begin
            lost_d       = 1'b1;
            fail_attempt = 1'b1;
          end else if (cnt_q == SETTLE_LAST) begin
            state_d = ST_MEASURE;
            cnt_d   = '0;
            acc_clr = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_MEASURE: begin
          // Words seen while unlocked are meaningless, so the loss cycle adds nothing.
          if (!dp.aligned_i) begin
            lost_d       = 1'b1;
            fail_attempt = 1'b1;
          end else begin
            acc_en = 1'b1;
            if (cnt_q == MEAS_LAST) begin
              state_d = ST_DONE;
              pass_d  = (acc_nxt <= ERR_W'(ERR_THRESH));
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase

      if (fail_attempt) begin
        if (retry_q < RETRY_W'(MAX_RETRY)) begin
          retry_d = retry_q + 1'b1;
          state_d = ST_RESET_DP;
          cnt_d   = '0;
        end else begin
          state_d = ST_DONE;
          pass_d  = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      retry_q <= '0;
      lost_q  <= 1'b0;
      addr_q  <= '0;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ext_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      lost_q  <= lost_d;
      addr_q  <= addr_d;
      pass_q  <= pass_d;
      busy_q  <= is_busy(state_d);
      done_q  <= (state_d == ST_DONE);
      ext_q   <= (state_d != ST_RESET_DP);
    end
  end

  sat_accum #(
    .W (ERR_W)
  ) u_err_acc (
    .clk   (clk),
    .reset (reset),
    .clr_i (acc_clr),
    .en_i  (acc_en),
    .add_i (dp.error_count_i),
    .acc_o (err_total),
    .nxt_o (acc_nxt)
  );

  assign dp.extract_rst_n_o = ext_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign pass               = pass_q;
  assign lock_lost          = lost_q;
  assign retry_count        = retry_q;
  assign lock_addr          = addr_q;
  assign state_o            = state_q;

endmodule
